// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv: multi-cycle multiply/divide unit holding the HI/LO registers.
// Implements MULT, MULTU, DIV, DIVU (iterative, WIDTH cycles) and MTHI/MTLO
// (single cycle) behind a start/busy/done handshake.
// Optional build macro: MULDIV_FAST_MULT_EN selects a combinational multiplier
// that writes HI/LO at the start edge; divide stays iterative.
module mips_cpu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   aRaw_q, aRaw_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               signRes_q, signRes_d;
  logic               signDvd_q, signDvd_d;
  logic               done_q, done_d;

  // Operand preparation: signed ops work on magnitudes, sign fixed at the end
  logic               opSigned;
  logic [WIDTH-1:0]   magA, magB;
  assign opSigned = (op == 3'd0) || (op == 3'd2);
  assign magA     = (opSigned && a[WIDTH-1]) ? -a : a;
  assign magB     = (opSigned && b[WIDTH-1]) ? -b : b;

  // Restoring divide step: acc holds {remainder, remaining dividend/quotient}
  logic [WIDTH:0]     divTrial;
  logic               divGe;
  logic [WIDTH-1:0]   divDiff;
  logic [2*WIDTH-1:0] divNext;
  logic [WIDTH-1:0]   divQuot, divRem;
  assign divTrial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign divGe    = divTrial >= {1'b0, opb_q};
  assign divDiff  = divTrial[WIDTH-1:0] - opb_q;
  assign divNext  = {(divGe ? divDiff : divTrial[WIDTH-1:0]), acc_q[WIDTH-2:0], divGe};
  assign divQuot  = divNext[WIDTH-1:0];
  assign divRem   = divNext[2*WIDTH-1:WIDTH];

`ifdef MULDIV_FAST_MULT_EN
  // Single-cycle product of the magnitudes, then two's complement if needed
  logic [2*WIDTH-1:0] fastMag, fastProd;
  assign fastMag  = {{WIDTH{1'b0}}, magA} * {{WIDTH{1'b0}}, magB};
  assign fastProd = (opSigned && (a[WIDTH-1] ^ b[WIDTH-1])) ? -fastMag : fastMag;
`else
  // Shift-add step: acc holds {partial product, remaining multiplier bits}
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext, mulProd;
  assign mulSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mulNext = {mulSum, acc_q[WIDTH-1:1]};
  assign mulProd = signRes_q ? -mulNext : mulNext;
`endif

  // Next-state logic: command decode in IDLE, one iteration per cycle otherwise
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    aRaw_d    = aRaw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    signRes_d = signRes_q;
    signDvd_d = signDvd_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            3'd0, 3'd1: begin
`ifdef MULDIV_FAST_MULT_EN
              hi_d   = fastProd[2*WIDTH-1:WIDTH];
              lo_d   = fastProd[WIDTH-1:0];
              done_d = 1'b1;
`else
              state_d   = MUL;
              acc_d     = {{WIDTH{1'b0}}, magB};
              opb_d     = magA;
              signRes_d = opSigned && (a[WIDTH-1] ^ b[WIDTH-1]);
              cnt_d     = '0;
`endif
            end
            3'd2, 3'd3: begin
              state_d   = DIV;
              acc_d     = {{WIDTH{1'b0}}, magA};
              opb_d     = magB;
              aRaw_d    = a;
              signRes_d = opSigned && (a[WIDTH-1] ^ b[WIDTH-1]);
              signDvd_d = opSigned && a[WIDTH-1];
              cnt_d     = '0;
            end
            3'd4: begin
              hi_d   = a;
              done_d = 1'b1;
            end
            3'd5: begin
              lo_d   = a;
              done_d = 1'b1;
            end
            default: begin
            end
          endcase
        end
      end
      MUL: begin
`ifdef MULDIV_FAST_MULT_EN
        state_d = IDLE;
`else
        acc_d = mulNext;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          hi_d    = mulProd[2*WIDTH-1:WIDTH];
          lo_d    = mulProd[WIDTH-1:0];
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
`endif
      end
      DIV: begin
        acc_d = divNext;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          if (opb_q == '0) begin
            lo_d = '1;
            hi_d = aRaw_q;
          end else begin
            lo_d = signRes_q ? -divQuot : divQuot;
            hi_d = signDvd_q ? -divRem : divRem;
          end
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously by reset_n
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      aRaw_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      signRes_q <= 1'b0;
      signDvd_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      aRaw_q    <= aRaw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      signRes_q <= signRes_d;
      signDvd_q <= signDvd_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// tb_mips_cpu_muldiv: directed, table-driven bench for mips_cpu_muldiv (WIDTH=32).
// Honours MULDIV_FAST_MULT_EN when computing the expected multiply latency.
module tb_mips_cpu_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int compared = 0;
  int mismatched = 0;

  logic [W-1:0] modelHi = '0;
  logic [W-1:0] modelLo = '0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] expHi;
    logic [W-1:0] expLo;
  } vec_t;

  vec_t vecs[16];

  mips_cpu_muldiv #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  // Compare one observed value against its expectation and tally the result
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Expected cycles from the start edge to the done cycle for a given op
  function automatic int expLatency(input logic [2:0] opIn);
    if (opIn <= 3'd1) begin
`ifdef MULDIV_FAST_MULT_EN
      return 0;
`else
      return W;
`endif
    end else if (opIn <= 3'd3) begin
      return W;
    end
    return 0;
  endfunction

  // Issue one command and follow it to its done pulse
  task automatic applyStimulus(input logic [2:0] opIn, input logic [W-1:0] aIn, input logic [W-1:0] bIn,
                               input logic [W-1:0] expHi, input logic [W-1:0] expLo, input string name);
    int cycles;
    int lat;
    bit holdOk;
    bit timedOut;
    lat = expLatency(opIn);
    @(negedge clk);
    start = 1'b1;
    op = opIn;
    a = aIn;
    b = bIn;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    cycles = 0;
    holdOk = 1'b1;
    timedOut = 1'b0;
    while (1) begin
      @(negedge clk);
      if (done) break;
      if (cycles > lat + 4) begin
        timedOut = 1'b1;
        break;
      end
      if (busy !== 1'b1 || hi !== modelHi || lo !== modelLo) holdOk = 1'b0;
      cycles++;
    end
    checkOutput({name, " timeout"}, 64'(timedOut), 64'd0);
    checkOutput({name, " latency"}, 64'(cycles), 64'(lat));
    checkOutput({name, " busy/hold"}, 64'(holdOk), 64'd1);
    checkOutput({name, " busy@done"}, 64'(busy), 64'd0);
    checkOutput({name, " hi"}, 64'(hi), 64'(expHi));
    checkOutput({name, " lo"}, 64'(lo), 64'(expLo));
    modelHi = expHi;
    modelLo = expLo;
    @(negedge clk);
    checkOutput({name, " done pulse width"}, 64'(done), 64'd0);
  endtask

  initial begin
    int pulses;

    vecs[0]  = '{3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4]  = '{3'd3, 32'h0000000A, 32'h00000000, 32'h0000000A, 32'hFFFFFFFF};
    vecs[5]  = '{3'd0, 32'h00000005, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF6};
    vecs[6]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[7]  = '{3'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[8]  = '{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[9]  = '{3'd2, 32'hFFFFFFF8, 32'h00000003, 32'hFFFFFFFE, 32'hFFFFFFFE};
    vecs[10] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[11] = '{3'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[12] = '{3'd4, 32'hCAFEBABE, 32'h00000000, 32'hCAFEBABE, 32'hFFFFFFFF};
    vecs[13] = '{3'd5, 32'h13579BDF, 32'h00000000, 32'hCAFEBABE, 32'h13579BDF};
    vecs[14] = '{3'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    vecs[15] = '{3'd0, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};

    // Reset values
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset hi", 64'(hi), 64'd0);
    checkOutput("reset lo", 64'(lo), 64'd0);
    reset_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expHi, vecs[i].expLo,
                    $sformatf("vec%0d op%0d", i, vecs[i].op));
    end

    // Reserved op 6: no state change and no done pulse
    @(negedge clk);
    start = 1'b1;
    op = 3'd6;
    a = 32'hDEADBEEF;
    b = 32'h1;
    @(posedge clk);
    #1;
    start = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    checkOutput("op6 no activity", 64'(pulses), 64'd0);
    checkOutput("op6 hi", 64'(hi), 64'(modelHi));
    checkOutput("op6 lo", 64'(lo), 64'(modelLo));

    // MTHI then MTLO on consecutive edges, each with its own done
    @(negedge clk);
    start = 1'b1;
    op = 3'd4;
    a = 32'h12345678;
    @(posedge clk);
    #1;
    op = 3'd5;
    a = 32'h9ABCDEF0;
    @(negedge clk);
    checkOutput("mthi done", 64'(done), 64'd1);
    checkOutput("mthi hi", 64'(hi), 64'h12345678);
    checkOutput("mthi lo kept", 64'(lo), 64'(modelLo));
    checkOutput("mthi busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("mtlo done", 64'(done), 64'd1);
    checkOutput("mtlo lo", 64'(lo), 64'h9ABCDEF0);
    checkOutput("mtlo hi kept", 64'(hi), 64'h12345678);
    modelHi = 32'h12345678;
    modelLo = 32'h9ABCDEF0;
    @(negedge clk);
    checkOutput("mtlo done drop", 64'(done), 64'd0);

    // Start requests during busy are ignored: exactly one done for DIVU 10/0
    @(negedge clk);
    start = 1'b1;
    op = 3'd3;
    a = 32'd10;
    b = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    op = 3'd4;
    a = 32'hDEADDEAD;
    repeat (4) @(negedge clk);
    start = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput("busy-start done count", 64'(pulses), 64'd1);
    checkOutput("busy-start hi", 64'(hi), 64'h0000000A);
    checkOutput("busy-start lo", 64'(lo), 64'hFFFFFFFF);
    modelHi = 32'h0000000A;
    modelLo = 32'hFFFFFFFF;

    // Asynchronous reset in the middle of a divide, then a clean rerun
    @(negedge clk);
    start = 1'b1;
    op = 3'd3;
    a = 32'd100;
    b = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    checkOutput("pre-reset busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("mid reset busy", 64'(busy), 64'd0);
    checkOutput("mid reset done", 64'(done), 64'd0);
    checkOutput("mid reset hi", 64'(hi), 64'd0);
    checkOutput("mid reset lo", 64'(lo), 64'd0);
    modelHi = '0;
    modelLo = '0;
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, "divu after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Overall time limit so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
